// File: rtl/tx_channel_arbiter.sv
// tx_channel_arbiter: round-robin arbiter sequencing a shared serial transmitter for NREQ requesters.
// Define TXARB_TIMEOUT_EN to add a WAIT_END watchdog that fails a transfer after TIMEOUT cycles.
module tx_channel_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2047
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   confirm,
  output logic [NREQ-1:0]   fail,
  output logic              busy,
  output logic              tx_load,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  input  logic              tx_end,
  input  logic              tx_error
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_END} state_t;
  state_t state;
  logic [2:0] rr_ptr, owner, win;
  logic [3:0] idx;
  logic [7:0] req_ext;
  logic [63:0] data_ext;
  logic [NREQ-1:0] win_hot;
  logic timed_out;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("tx_channel_arbiter: parameter out of range");
  end
  assign req_ext  = 8'(req);
  assign data_ext = 64'(req_data);
  // Scan downward so the lowest circular offset from rr_ptr is the last write and wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      idx = idx >= 4'(NREQ) ? idx - 4'(NREQ) : idx;
      win = req_ext[idx[2:0]] ? idx[2:0] : win;
    end
  end
  always_comb begin
    win_hot = '0;
    for (int i = 0; i < NREQ; i++) win_hot[i] = win == 3'(i);
  end
`ifdef TXARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) wd_cnt <= '0;
    else wd_cnt <= state == WAIT_END ? wd_cnt + 16'd1 : '0;
  assign timed_out = wd_cnt == 16'(TIMEOUT);
`else
  assign timed_out = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      grant   <= '0;
      confirm <= '0;
      fail    <= '0;
      busy    <= 1'b0;
      tx_load <= 1'b0;
      tx_send <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      confirm <= '0;
      fail    <= '0;
      case (state)
        IDLE: if (|req) begin
          state   <= LOAD;
          owner   <= win;
          grant   <= win_hot;
          tx_data <= data_ext[{win, 3'b000} +: 8];
          tx_load <= 1'b1;
          busy    <= 1'b1;
        end
        LOAD: begin
          state   <= SEND;
          tx_load <= 1'b0;
          tx_send <= 1'b1;
        end
        SEND: begin
          state   <= WAIT_END;
          tx_send <= 1'b0;
        end
        WAIT_END: if (tx_error || tx_end || timed_out) begin
          state   <= IDLE;
          fail    <= (tx_error || !tx_end) ? grant : '0;
          confirm <= (!tx_error && tx_end) ? grant : '0;
          grant   <= '0;
          busy    <= 1'b0;
          rr_ptr  <= owner == 3'(NREQ - 1) ? '0 : owner + 3'd1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tx_channel_arbiter.sv
// tb_tx_channel_arbiter: randomized self-checking bench with a queue-free round-robin reference model.
module tb_tx_channel_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_data = '0;
  logic [3:0] grant, confirm, fail;
  logic busy, tx_load, tx_send;
  logic [7:0] tx_data;
  logic tx_end = 1'b0;
  logic tx_error = 1'b0;
  int checks = 0;
  int fails = 0;
  int model_ptr = 0;

  always #5 clock = ~clock;

  tx_channel_arbiter #(.NREQ(4), .TIMEOUT(5)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .confirm(confirm), .fail(fail), .busy(busy),
    .tx_load(tx_load), .tx_send(tx_send), .tx_data(tx_data),
    .tx_end(tx_end), .tx_error(tx_error)
  );

  // Reference: first requester at or after the priority pointer, wrapping around.
  function automatic int pick(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[(model_ptr + i) % 4]) return (model_ptr + i) % 4;
    return 0;
  endfunction

  // Drives one transfer starting at a negedge in IDLE and checks every cycle of it.
  task automatic run_xfer(input logic [3:0] r, input logic [31:0] d, input int wt,
                          input bit err, input bit endv, input bit keep, input bit drop, input bit spur);
    int w;
    logic [3:0] eg, ec, ef;
    logic [7:0] ed;
    w = pick(r);
    eg = 4'b0001 << w;
    ed = d[8*w +: 8];
    req = r;
    req_data = d;
    @(negedge clock);
    checks++;
    if (grant !== eg) begin fails++; $display("FAIL grant: got %b want %b", grant, eg); end
    checks++;
    if (tx_data !== ed) begin fails++; $display("FAIL tx_data: got %h want %h", tx_data, ed); end
    checks++;
    if ({tx_load, tx_send, busy} !== 3'b101) begin
      fails++; $display("FAIL load_phase load/send/busy: got %b want 101", {tx_load, tx_send, busy});
    end
    checks++;
    if ({confirm, fail} !== 8'h00) begin fails++; $display("FAIL early_pulse: got %b want 0", {confirm, fail}); end
    if (drop) req = '0;
    tx_end = spur;
    @(negedge clock);
    checks++;
    if ({tx_load, tx_send, grant} !== {2'b01, eg}) begin
      fails++; $display("FAIL send_phase load/send/grant: got %b want %b", {tx_load, tx_send, grant}, {2'b01, eg});
    end
    tx_end = 1'b0;
    tx_error = spur;
    @(negedge clock);
    checks++;
    if ({tx_load, tx_send, busy, grant, confirm, fail} !== {3'b001, eg, 8'h00}) begin
      fails++; $display("FAIL wait_entry state: got %b want %b", {tx_load, tx_send, busy, grant, confirm, fail}, {3'b001, eg, 8'h00});
    end
    tx_error = 1'b0;
    for (int k = 0; k < wt; k++) begin
      @(negedge clock);
      checks++;
      if ({busy, grant, confirm, fail} !== {1'b1, eg, 8'h00}) begin
        fails++; $display("FAIL wait_hold cycle %0d: got %b want %b", k, {busy, grant, confirm, fail}, {1'b1, eg, 8'h00});
      end
    end
    tx_end = endv;
    tx_error = err;
    @(negedge clock);
    ec = (endv && !err) ? eg : 4'b0000;
    ef = (err || !endv) ? eg : 4'b0000;
    checks++;
    if (confirm !== ec) begin fails++; $display("FAIL confirm: got %b want %b", confirm, ec); end
    checks++;
    if (fail !== ef) begin fails++; $display("FAIL fail: got %b want %b", fail, ef); end
    checks++;
    if ({grant, busy, tx_load, tx_send} !== 7'b0) begin
      fails++; $display("FAIL done_idle grant/busy/load/send: got %b want 0", {grant, busy, tx_load, tx_send});
    end
    checks++;
    if (tx_data !== ed) begin fails++; $display("FAIL tx_data_hold: got %h want %h", tx_data, ed); end
    tx_end = 1'b0;
    tx_error = 1'b0;
    model_ptr = (w + 1) % 4;
    if (!keep) req = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if ({grant, confirm, fail, busy, tx_load, tx_send, tx_data} !== 23'b0) begin
      fails++; $display("FAIL reset_values: got %b want 0", {grant, confirm, fail, busy, tx_load, tx_send, tx_data});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({grant, busy, tx_load} !== 6'b0) begin fails++; $display("FAIL post_reset_idle: got %b want 0", {grant, busy, tx_load}); end
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 5; i++) run_xfer(4'b1111, $urandom(), 1, 1'b0, 1'b1, i < 4, 1'b0, 1'b0);
  endtask

  task automatic test_single();
    run_xfer(4'b0100, 32'h00A5_0000, 9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (model_ptr != 3) begin fails++; $display("FAIL model_ptr: got %0d want 3", model_ptr); end
    run_xfer(4'b1001, 32'h1122_3344, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_error();
    run_xfer(4'b0010, 32'hDEAD_BEEF, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    req_data = 32'h0077_0000;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (tx_send !== 1'b1) begin fails++; $display("FAIL pre_reset_send: got %b want 1", tx_send); end
    reset = 1'b1;
    #1;
    checks++;
    if ({grant, confirm, fail, busy, tx_load, tx_send, tx_data} !== 23'b0) begin
      fails++; $display("FAIL async_reset: got %b want 0", {grant, confirm, fail, busy, tx_load, tx_send, tx_data});
    end
    req = '0;
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0;
    @(negedge clock);
    checks++;
    if ({confirm, fail, busy} !== 9'b0) begin fails++; $display("FAIL reset_no_pulse: got %b want 0", {confirm, fail, busy}); end
    run_xfer(4'b1001, $urandom(), 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_drop_spurious();
    run_xfer(4'b0100, $urandom(), 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    checks++;
    if ({grant, busy} !== 5'b0) begin fails++; $display("FAIL drop_no_regrant: got %b want 0", {grant, busy}); end
    tx_end = 1'b1;
    @(negedge clock);
    tx_end = 1'b0;
    tx_error = 1'b1;
    checks++;
    if ({confirm, fail, busy, grant} !== 13'b0) begin fails++; $display("FAIL idle_end: got %b want 0", {confirm, fail, busy, grant}); end
    @(negedge clock);
    tx_error = 1'b0;
    checks++;
    if ({confirm, fail, busy, grant} !== 13'b0) begin fails++; $display("FAIL idle_error: got %b want 0", {confirm, fail, busy, grant}); end
  endtask

  task automatic test_timeout();
`ifdef TXARB_TIMEOUT_EN
    run_xfer(4'b1000, $urandom(), 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    run_xfer(4'b0001, $urandom(), 1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    logic [3:0] r;
    bit e, n;
    for (int i = 0; i < 40; i++) begin
      r = 4'($urandom_range(1, 15));
      e = 1'($urandom_range(0, 1));
      n = e ? 1'($urandom_range(0, 1)) : 1'b1;
      run_xfer(r, $urandom(), $urandom_range(0, 4), e, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    req = '0;
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_error();
    test_reset_mid();
    test_drop_spurious();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/tx_channel_arbiter.md
# tx_channel_arbiter

Round-robin arbiter that shares a single 8-bit serial transmitter among `NREQ` requesters. It sequences the transmitter's load/send/tx_end handshake on behalf of the granted requester. It returns a one-cycle `confirm` on completion or `fail` on error to that requester only. It sits between the acquisition-side channel FSMs and the serial interface/transmitter pair.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; legal range 2..8.
- `TIMEOUT`, 2047, WAIT_END watchdog limit in cycles; legal range 1..65535. Used only with `TXARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester transmit request (level).
- `req_data`  in  8*NREQ  byte for requester i on bits [8i+7:8i].
- `grant`  out  NREQ  one-hot owner of the transmitter; all-zero when idle.
- `confirm`  out  NREQ  one-cycle pulse to the owner on successful completion.
- `fail`  out  NREQ  one-cycle pulse to the owner on error or timeout.
- `busy`  out  1  high in every state except IDLE.
- `tx_load`  out  1  transmitter load strobe.
- `tx_send`  out  1  transmitter send strobe.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_end`  in  1  transmitter end-of-frame pulse.
- `tx_error`  in  1  transmitter error flag.

## Operation
- States are IDLE, LOAD, SEND and WAIT_END.
- All outputs are registered. A 3-bit `rr_ptr` holds the highest-priority index.
- **IDLE:** if `req != 0`, select the first set bit scanning circularly from `rr_ptr`. The next edge does all of the following:
  - sets `grant` one-hot to the winner;
  - latches the winner's `req_data` slice into `tx_data`;
  - sets `tx_load=1`;
  - moves to LOAD.
- **LOAD:** next edge sets `tx_load=0`, `tx_send=1` and moves to SEND.
- **SEND:** next edge sets `tx_send=0` and moves to WAIT_END.
- **WAIT_END:** the FSM ends the transfer on the first matching condition:
  - if `tx_error=1`: pulse `fail[g]`, go to IDLE;
  - else if `tx_end=1`: pulse `confirm[g]`, go to IDLE.
- On every return to IDLE: `grant` clears and `rr_ptr` becomes `(g+1) mod NREQ`.
- `tx_data` holds its value until the next grant.
- `req` is sampled only in IDLE. Dropping `req` mid-transfer does not abort the transfer; `confirm`/`fail` is still pulsed.
- `tx_end` and `tx_error` are ignored in IDLE, LOAD and SEND.
- Simultaneous `tx_end` and `tx_error` in WAIT_END resolves to `fail`.
- Invariants:
  - `tx_load` and `tx_send` are never both high.
  - `confirm` and `fail` are never both high.
  - At most one bit of `grant` is set.

## Timing
- Reset values:
  - `grant=0`, `confirm=0`, `fail=0`, `busy=0`;
  - `tx_load=0`, `tx_send=0`, `tx_data=8'h00`;
  - `rr_ptr=0`, state IDLE, watchdog count 0.
- Reset mid-transfer forces reset values immediately (asynchronous), with no `confirm`/`fail` pulse.
- Transfer sequence, with `req` sampled high at edge E0:
  - E0: `grant` and `tx_load` go high after this edge.
  - E1: `tx_send` is high for exactly one cycle.
  - E2: WAIT_END is entered.
- `tx_end` sampled at edge Ek raises `confirm` for the cycle after Ek, with `grant=0` in that same cycle.
- Minimum spacing between successive `tx_load` pulses is 4 cycles: one IDLE cycle is always inserted.
- Fairness: with every requester continuously asserting, each requester is granted exactly once per `NREQ` transfers.

## Configuration
- `TXARB_TIMEOUT_EN` defined:
  - a 16-bit counter clears on WAIT_END entry and increments each WAIT_END cycle;
  - if it reaches `TIMEOUT` with no `tx_end`/`tx_error`, the next edge pulses `fail[g]`, returns to IDLE and advances `rr_ptr`.
- `TXARB_TIMEOUT_EN` undefined: no counter exists; WAIT_END waits indefinitely; `TIMEOUT` is unused.

## Test plan
- **Single request:** `req=4'b0100`, `req_data[23:16]=8'hA5`, then `tx_end` 10 cycles after `tx_send`. Expect:
  - `grant=4'b0100`, `tx_data=8'hA5`;
  - `tx_load` and `tx_send` each high for one cycle, in consecutive cycles;
  - `confirm=4'b0100` for one cycle;
  - `rr_ptr=3`.
- **Round robin:** `req=4'b1111` held, `tx_end` for each transfer. Expect grant order 0001, 0010, 0100, 1000, 0001; IDLE cycle between transfers.
- **Error:** `tx_error=1` together with `tx_end` in WAIT_END for requester 1. Expect `fail=4'b0010`, `confirm=0`, then return to IDLE.
- **Reset mid-transfer:** assert `reset` during SEND. Expect all outputs 0 in the same cycle, no pulse, and after release `req=4'b0001` is granted first.
- **Timeout** (`TXARB_TIMEOUT_EN`, `TIMEOUT=5`): no `tx_end`. Expect `fail[g]` 6 cycles after WAIT_END entry. Without the macro, `busy` stays high for 1000 cycles.
- **Request drop and spurious end:** `req` dropped after grant still yields `confirm`; `tx_end` in IDLE produces no pulse.
